neureka_col_pres_accumulator: RTL and testbench
===============================================

Name: neureka_col_pres_accumulator

Overview:
- Consumer at the far end of the column partial-result stream: the sink for the scaled per-column results produced by a binconv column.
- Accepts a programmed number of partial results, sign-extends and accumulates them, then presents one accumulated word on an output stream toward the accumulator bank.
- One instance per column; sequencing is under engine-controller control via a start pulse and length.

Parameters:
- IN_WIDTH, 28, width of incoming column partial result (scaled column width).
- ACC_WIDTH, 32, width of accumulator and output data; must be >= IN_WIDTH.
- LEN_WIDTH, 8, width of the partial-result count per output.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- enable_i  input  1  local enable; low = stall, all state held
- clear_i  input  1  synchronous soft clear; same effect as rst_i
- start_i  input  1  single-cycle start of one accumulation job
- len_i  input  LEN_WIDTH  number of partial results per job, sampled on accepted start_i
- signed_i  input  1  1 = sign-extend input, 0 = zero-extend; sampled on accepted start_i
- col_pres_i  hwpe_stream sink  IN_WIDTH  incoming column partial results (valid/ready/data/strb; strb ignored)
- acc_o  hwpe_stream source  ACC_WIDTH  accumulated result (strb driven all-ones)
- busy_o  output  1  high in ACCUM or OUTPUT
- done_o  output  1  one-cycle pulse on the acc_o handshake
- overflow_o  output  1  sticky; set on signed/unsigned overflow of any add in the current job, cleared on accepted start_i

Behaviour:
- Reset (rst_i or clear_i) values:
  - FSM IDLE; acc register 0; count 0.
  - acc_o.valid=0, acc_o.data=0, col_pres_i.ready=0.
  - busy_o=0, done_o=0, overflow_o=0.
  - Reset or clear mid-job aborts the job; no output is produced.
- enable_i=0 (with no reset/clear):
  - All registers hold.
  - col_pres_i.ready forced 0.
  - acc_o.valid holds its value; acc_o.data stays stable.
  - A start_i arriving while enable_i=0 is ignored.
- FSM states IDLE, ACCUM, OUTPUT:
  - IDLE: on start_i & enable_i, latch len and signed, acc<=0, count<=0, overflow<=0.
    - len_i!=0 -> ACCUM.
    - len_i==0 -> OUTPUT with data 0.
  - ACCUM: col_pres_i.ready=1.
    - On handshake: acc<=acc+ext(data), count<=count+1.
    - When count==len-1 at handshake -> OUTPUT.
  - OUTPUT: acc_o.valid=1, acc_o.data=acc, col_pres_i.ready=0.
    - On acc_o.ready -> IDLE, done_o=1 for that cycle.
    - Data and valid must not change while valid & ~ready.
- Latency: last input handshake in cycle t -> acc_o.valid=1 in cycle t+1 carrying the full sum. Back-to-back jobs: new start_i is accepted in the cycle after the output handshake at the earliest.
- start_i outside IDLE is ignored (no restart, no error).
- Arithmetic:
  - ext() sign- or zero-extends IN_WIDTH to ACC_WIDTH per the latched signed flag.
  - Default addition wraps modulo 2^ACC_WIDTH.
  - Overflow detection: signed = operands share a sign and the result sign differs; unsigned = carry out of the MSB.
- Count register is LEN_WIDTH bits; len=2^LEN_WIDTH-1 is the maximum job.
- Input data when valid is low is don't-care and never accumulated.

Optional Feature:
- Macro NEUREKA_ACC_SATURATE_EN.
- Defined: on overflow the accumulator clamps.
  - Signed: to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
  - Unsigned: to 2^ACC_WIDTH-1.
  - Subsequent adds continue from the clamped value; overflow_o behaves the same.
- Undefined: wrap-around arithmetic; saturation logic absent.

Test Plan:
- Unsigned basic: start len=4 signed=0, inputs 1,2,3,4 on consecutive cycles with acc_o.ready=1 -> acc_o.data=10 one cycle after the 4th handshake; done_o pulses; overflow_o=0.
- Signed with backpressure: len=3 signed=1, inputs -5,+2,-1 (IN_WIDTH two's complement), acc_o.ready low 5 cycles -> acc_o.data=0xFFFFFFFC held stable with valid high until ready; then IDLE.
- Input gaps and stall: len=3, col_pres_i.valid toggled 1,0,1,0,1, with enable_i=0 for 2 mid-job cycles -> only the 3 valid beats are summed; no ready while disabled; result correct.
- len=0 and ignored start: start len=0 -> acc_o.valid next cycle with data 0. A second start_i during OUTPUT -> ignored; busy_o stays high until handshake.
- Overflow: ACC_WIDTH=IN_WIDTH=8 override, signed, inputs 100,100 -> wrap build gives 0xC8 with overflow_o=1; NEUREKA_ACC_SATURATE_EN build gives 0x7F with overflow_o=1.
- Clear mid-job: clear_i after 2 of 4 beats -> ready=0, busy_o=0, no output. A following job len=1 input 7 -> output 7.

Source files
------------

// File: rtl/neureka_col_pres_accumulator.sv
// Column partial-result sink: accumulates a programmed number of beats and emits one word.
// Define NEUREKA_ACC_SATURATE_EN to clamp on overflow instead of wrapping modulo 2^ACC_WIDTH.
module neureka_col_pres_accumulator #(
  parameter int unsigned IN_WIDTH  = 28,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned LEN_WIDTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         enable_i,
  input  logic                         clear_i,
  input  logic                         start_i,
  input  logic [LEN_WIDTH-1:0]         len_i,
  input  logic                         signed_i,
  input  logic                         col_pres_valid_i,
  output logic                         col_pres_ready_o,
  input  logic [IN_WIDTH-1:0]          col_pres_data_i,
  input  logic [(IN_WIDTH+7)/8-1:0]    col_pres_strb_i,
  output logic                         acc_valid_o,
  input  logic                         acc_ready_i,
  output logic [ACC_WIDTH-1:0]         acc_data_o,
  output logic [(ACC_WIDTH+7)/8-1:0]   acc_strb_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         overflow_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUTPUT
  } state_e;

  state_e               r_state;
  state_e               w_next_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [LEN_WIDTH-1:0] r_count;
  logic [LEN_WIDTH-1:0] r_len;
  logic                 r_signed;
  logic                 r_overflow;

  logic                 w_reset;
  logic                 w_start;
  logic                 w_in_hs;
  logic                 w_last;
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH:0]   w_sum_full;
  logic                 w_ovf_signed;
  logic                 w_ovf;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic                 w_unused_strb;

  assign w_unused_strb = ^col_pres_strb_i;

  assign w_reset = rst_i | clear_i;
  assign w_start = (r_state == IDLE) & start_i & enable_i;
  assign w_in_hs = (r_state == ACCUM) & enable_i & col_pres_valid_i;
  assign w_last  = (r_count == r_len - LEN_WIDTH'(1));

  // Widen the incoming beat; upper bits follow the job's latched signedness.
  always_comb begin
    w_ext = '0;
    w_ext[IN_WIDTH-1:0] = col_pres_data_i;
    for (int k = IN_WIDTH; k < ACC_WIDTH; k++) begin
      w_ext[k] = r_signed & col_pres_data_i[IN_WIDTH-1];
    end
  end

  assign w_sum_full   = {1'b0, r_acc} + {1'b0, w_ext};
  assign w_ovf_signed = (r_acc[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1]) &&
                        (w_sum_full[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
  assign w_ovf        = r_signed ? w_ovf_signed : w_sum_full[ACC_WIDTH];

`ifdef NEUREKA_ACC_SATURATE_EN
  // Signed overflow can only happen when both operands share r_acc's sign, so it picks the rail.
  always_comb begin
    w_acc_next = w_sum_full[ACC_WIDTH-1:0];
    if (w_ovf) begin
      if (!r_signed) begin
        w_acc_next = {ACC_WIDTH{1'b1}};
      end else if (r_acc[ACC_WIDTH-1]) begin
        w_acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      end else begin
        w_acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end
  end
`else
  assign w_acc_next = w_sum_full[ACC_WIDTH-1:0];
`endif

  always_ff @(posedge clk_i) begin
    if (w_reset) begin
      r_state <= IDLE;
    end else if (enable_i) begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_next_state = (len_i == '0) ? OUTPUT : ACCUM;
        end
      end
      ACCUM: begin
        if (w_in_hs && w_last) begin
          w_next_state = OUTPUT;
        end
      end
      OUTPUT: begin
        if (acc_ready_i) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    col_pres_ready_o = (r_state == ACCUM) & enable_i;
    acc_valid_o      = (r_state == OUTPUT);
    acc_data_o       = (r_state == OUTPUT) ? r_acc : '0;
    acc_strb_o       = '1;
    busy_o           = (r_state != IDLE);
    done_o           = (r_state == OUTPUT) & acc_ready_i & enable_i;
    overflow_o       = r_overflow;
  end

  always_ff @(posedge clk_i) begin
    if (w_reset) begin
      r_acc      <= '0;
      r_count    <= '0;
      r_len      <= '0;
      r_signed   <= 1'b0;
      r_overflow <= 1'b0;
    end else if (enable_i) begin
      if (w_start) begin
        r_acc      <= '0;
        r_count    <= '0;
        r_len      <= len_i;
        r_signed   <= signed_i;
        r_overflow <= 1'b0;
      end else if (w_in_hs) begin
        r_acc   <= w_acc_next;
        r_count <= r_count + LEN_WIDTH'(1);
        if (w_ovf) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_neureka_col_pres_accumulator.sv
// Self-checking bench for neureka_col_pres_accumulator: randomized jobs against an arithmetic model.
// Honours NEUREKA_ACC_SATURATE_EN so the model follows whichever build is under test.
module tb_neureka_col_pres_accumulator;

  localparam int IN_W  = 28;
  localparam int ACC_W = 32;
  localparam int LEN_W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                enable;
  logic                clear;
  logic                start;
  logic [LEN_W-1:0]    lenIn;
  logic                sgnIn;
  logic                inValid;
  logic                inReady;
  logic [IN_W-1:0]     inData;
  logic [3:0]          inStrb;
  logic                accValid;
  logic                accReady;
  logic [ACC_W-1:0]    accData;
  logic [3:0]          accStrb;
  logic                busy;
  logic                done;
  logic                ovf;

  logic                start8;
  logic [LEN_W-1:0]    len8;
  logic                sgn8;
  logic                inValid8;
  logic                inReady8;
  logic [7:0]          inData8;
  logic [0:0]          inStrb8;
  logic                accValid8;
  logic                accReady8;
  logic [7:0]          accData8;
  logic [0:0]          accStrb8;
  logic                busy8;
  logic                done8;
  logic                ovf8;

  int checks = 0;
  int errors = 0;

  logic [IN_W-1:0]  beatData [0:299];
  logic [ACC_W-1:0] jobData;
  logic             jobOvf;
  bit               jobTimeout, jobLatOk, jobStableOk, jobDoneOk, jobIdleOk, jobStallOk;

  always #5 clk = ~clk;

  neureka_col_pres_accumulator #(.IN_WIDTH(IN_W), .ACC_WIDTH(ACC_W), .LEN_WIDTH(LEN_W)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
    .start_i(start), .len_i(lenIn), .signed_i(sgnIn),
    .col_pres_valid_i(inValid), .col_pres_ready_o(inReady),
    .col_pres_data_i(inData), .col_pres_strb_i(inStrb),
    .acc_valid_o(accValid), .acc_ready_i(accReady),
    .acc_data_o(accData), .acc_strb_o(accStrb),
    .busy_o(busy), .done_o(done), .overflow_o(ovf)
  );

  neureka_col_pres_accumulator #(.IN_WIDTH(8), .ACC_WIDTH(8), .LEN_WIDTH(LEN_W)) dut8 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
    .start_i(start8), .len_i(len8), .signed_i(sgn8),
    .col_pres_valid_i(inValid8), .col_pres_ready_o(inReady8),
    .col_pres_data_i(inData8), .col_pres_strb_i(inStrb8),
    .acc_valid_o(accValid8), .acc_ready_i(accReady8),
    .acc_data_o(accData8), .acc_strb_o(accStrb8),
    .busy_o(busy8), .done_o(done8), .overflow_o(ovf8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Exact-integer sum of the first n beats, folded back into the w-bit range after every add.
  function automatic void refModel(input int w, input int inw, input int n, input bit s,
                                   output longint res, output bit ovfOut);
    longint acc, val, lo, hi, span;
    span = longint'(1) << w;
    lo = s ? -(span / 2) : 0;
    hi = s ? (span / 2 - 1) : (span - 1);
    acc = 0;
    ovfOut = 1'b0;
    for (int i = 0; i < n; i++) begin
      val = longint'(beatData[i]) & ((longint'(1) << inw) - 1);
      if (s && ((val >> (inw - 1)) & 1) == 1) val = val - (longint'(1) << inw);
      acc = acc + val;
      if (acc > hi) begin
        ovfOut = 1'b1;
`ifdef NEUREKA_ACC_SATURATE_EN
        acc = hi;
`else
        acc = acc - span;
`endif
      end else if (acc < lo) begin
        ovfOut = 1'b1;
`ifdef NEUREKA_ACC_SATURATE_EN
        acc = lo;
`else
        acc = acc + span;
`endif
      end
    end
    res = (acc < 0) ? acc + span : acc;
  endfunction

  // Drives one job on the main DUT; gapMode 0=dense, 1=alternating valid, 2=random gaps.
  task automatic runJob(input int n, input bit s, input int gapMode, input int stallAfter,
                        input int readyDelay);
    int sent, cycles;
    bit v, stalled, hs;
    logic [ACC_W-1:0] firstData;
    jobTimeout = 0; jobLatOk = 1; jobStableOk = 1; jobDoneOk = 1; jobIdleOk = 1; jobStallOk = 1;
    start = 1'b1; lenIn = n[LEN_W-1:0]; sgnIn = s;
    step();
    start = 1'b0; lenIn = LEN_W'($urandom); sgnIn = 1'($urandom);
    sent = 0; cycles = 0; stalled = 0;
    while (sent < n && cycles < 3000) begin
      if (sent == stallAfter && !stalled) begin
        enable = 1'b0; inValid = 1'b1; inData = IN_W'($urandom);
        for (int k = 0; k < 2; k++) begin
          #1;
          if (inReady !== 1'b0) jobStallOk = 0;
          step();
        end
        enable = 1'b1; stalled = 1;
      end
      case (gapMode)
        0:       v = 1'b1;
        1:       v = (cycles % 2 == 0);
        default: v = ($urandom_range(99) >= 30);
      endcase
      inValid = v;
      inData  = v ? beatData[sent] : IN_W'($urandom);
      #1;
      hs = inValid && inReady;
      step();
      cycles++;
      if (hs) sent++;
    end
    inValid = 1'b0;
    if (sent < n) jobTimeout = 1;
    if (accValid !== 1'b1) jobLatOk = 0;
    firstData = accData;
    jobData = accData;
    jobOvf = ovf;
    accReady = 1'b0;
    for (int k = 0; k < readyDelay; k++) begin
      step();
      if (accValid !== 1'b1 || accData !== firstData || busy !== 1'b1 || done !== 1'b0)
        jobStableOk = 0;
    end
    accReady = 1'b1;
    #1;
    if (done !== 1'b1) jobDoneOk = 0;
    step();
    accReady = 1'b0;
    #1;
    if (done !== 1'b0 || busy !== 1'b0 || accValid !== 1'b0) jobIdleOk = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; clear = 1'b0; start = 1'b0; lenIn = '0; sgnIn = 1'b0;
    inValid = 1'b0; inData = '0; inStrb = '1; accReady = 1'b0;
    start8 = 1'b0; len8 = '0; sgn8 = 1'b0; inValid8 = 1'b0; inData8 = '0; inStrb8 = '1;
    accReady8 = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++;
    if (accValid !== 1'b0 || inReady !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_handshake: valid=%b ready=%b expected 0 0", accValid, inReady);
    end
    checks++;
    if (accData !== '0) begin
      errors++; $display("[TB] FAIL reset_data: got %h expected 0", accData);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_status: busy=%b done=%b ovf=%b expected 0 0 0", busy, done, ovf);
    end
  endtask

  task automatic test_unsigned_basic();
    longint expRes; bit expOvf;
    for (int i = 0; i < 4; i++) beatData[i] = IN_W'(i + 1);
    refModel(ACC_W, IN_W, 4, 1'b0, expRes, expOvf);
    runJob(4, 1'b0, 0, -1, 0);
    checks++;
    if (jobData !== 32'd10 || jobData !== expRes[31:0]) begin
      errors++; $display("[TB] FAIL basic_data: got %h expected %h", jobData, 32'd10);
    end
    checks++;
    if (!jobLatOk || jobTimeout) begin
      errors++; $display("[TB] FAIL basic_latency: valid_next_cycle=%0d expected 1", jobLatOk);
    end
    checks++;
    if (!jobDoneOk || !jobIdleOk || jobOvf !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_done: done=%0d idle=%0d ovf=%b expected 1 1 0",
                         jobDoneOk, jobIdleOk, jobOvf);
    end
  endtask

  task automatic test_signed_backpressure();
    beatData[0] = 28'hFFFFFFB;
    beatData[1] = 28'h0000002;
    beatData[2] = 28'hFFFFFFF;
    runJob(3, 1'b1, 0, -1, 5);
    checks++;
    if (jobData !== 32'hFFFFFFFC) begin
      errors++; $display("[TB] FAIL signed_data: got %h expected FFFFFFFC", jobData);
    end
    checks++;
    if (!jobStableOk || !jobDoneOk || !jobIdleOk) begin
      errors++; $display("[TB] FAIL signed_backpressure: stable=%0d done=%0d idle=%0d expected 1 1 1",
                         jobStableOk, jobDoneOk, jobIdleOk);
    end
    checks++;
    if (jobOvf !== 1'b0) begin
      errors++; $display("[TB] FAIL signed_ovf: got %b expected 0", jobOvf);
    end
  endtask

  task automatic test_gaps_stall();
    longint expRes; bit expOvf, s;
    for (int i = 0; i < 3; i++) beatData[i] = IN_W'($urandom);
    s = 1'($urandom);
    refModel(ACC_W, IN_W, 3, s, expRes, expOvf);
    runJob(3, s, 1, 1, 1);
    checks++;
    if (jobData !== expRes[31:0] || jobTimeout) begin
      errors++; $display("[TB] FAIL gaps_data: got %h expected %h", jobData, expRes[31:0]);
    end
    checks++;
    if (!jobStallOk) begin
      errors++; $display("[TB] FAIL stall_ready: ready seen while disabled, expected 0");
    end
    checks++;
    if (jobOvf !== expOvf || !jobLatOk) begin
      errors++; $display("[TB] FAIL gaps_status: ovf=%b lat=%0d expected %b 1", jobOvf, jobLatOk, expOvf);
    end
  endtask

  task automatic test_len_zero();
    start = 1'b1; lenIn = '0; sgnIn = 1'b0; accReady = 1'b0;
    step();
    start = 1'b0;
    checks++;
    if (accValid !== 1'b1 || accData !== '0 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL len0_output: valid=%b data=%h busy=%b expected 1 0 1",
                         accValid, accData, busy);
    end
    start = 1'b1; lenIn = 8'd5;
    step();
    start = 1'b0;
    step();
    checks++;
    if (accValid !== 1'b1 || accData !== '0 || busy !== 1'b1 || inReady !== 1'b0) begin
      errors++; $display("[TB] FAIL ignored_start: valid=%b data=%h busy=%b ready=%b expected 1 0 1 0",
                         accValid, accData, busy, inReady);
    end
    accReady = 1'b1;
    #1;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("[TB] FAIL len0_done: got %b expected 1", done);
    end
    step();
    accReady = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || accValid !== 1'b0 || inReady !== 1'b0) begin
      errors++; $display("[TB] FAIL len0_idle: busy=%b valid=%b ready=%b expected 0 0 0",
                         busy, accValid, inReady);
    end
  endtask

  task automatic test_overflow32();
    logic [IN_W-1:0] pattern [0:2];
    bit sgn [0:2];
    longint expRes; bit expOvf;
    pattern[0] = 28'hFFFFFFF; sgn[0] = 1'b0;
    pattern[1] = 28'h7FFFFFF; sgn[1] = 1'b1;
    pattern[2] = 28'h8000000; sgn[2] = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 20; i++) beatData[i] = pattern[p];
      refModel(ACC_W, IN_W, 20, sgn[p], expRes, expOvf);
      runJob(20, sgn[p], 0, -1, 0);
      checks++;
      if (jobData !== expRes[31:0] || jobTimeout) begin
        errors++; $display("[TB] FAIL ovf32_data[%0d]: got %h expected %h", p, jobData, expRes[31:0]);
      end
      checks++;
      if (jobOvf !== 1'b1) begin
        errors++; $display("[TB] FAIL ovf32_flag[%0d]: got %b expected 1", p, jobOvf);
      end
    end
  endtask

  task automatic test_back_to_back();
    longint expRes; bit expOvf;
    for (int j = 0; j < 3; j++) begin
      beatData[0] = IN_W'(j + 3);
      beatData[1] = IN_W'(j * 11);
      refModel(ACC_W, IN_W, 2, 1'b0, expRes, expOvf);
      runJob(2, 1'b0, 0, -1, 0);
      checks++;
      if (jobData !== expRes[31:0] || jobOvf !== 1'b0 || !jobLatOk) begin
        errors++; $display("[TB] FAIL b2b[%0d]: data=%h ovf=%b expected %h 0", j, jobData, jobOvf,
                           expRes[31:0]);
      end
    end
  endtask

  task automatic test_random_jobs();
    longint expRes; bit expOvf, s; int n;
    for (int j = 0; j < 25; j++) begin
      n = $urandom_range(12, 1);
      s = 1'($urandom);
      for (int i = 0; i < n; i++)
        beatData[i] = ($urandom_range(1) == 1) ? IN_W'($urandom) : IN_W'($urandom_range(200));
      refModel(ACC_W, IN_W, n, s, expRes, expOvf);
      runJob(n, s, 2, -1, $urandom_range(3));
      checks++;
      if (jobData !== expRes[31:0] || jobOvf !== expOvf || jobTimeout) begin
        errors++; $display("[TB] FAIL random[%0d]: data=%h ovf=%b expected %h %b", j, jobData, jobOvf,
                           expRes[31:0], expOvf);
      end
      checks++;
      if (!jobLatOk || !jobStableOk || !jobDoneOk || !jobIdleOk) begin
        errors++; $display("[TB] FAIL random_proto[%0d]: lat=%0d stable=%0d done=%0d idle=%0d expected 1",
                           j, jobLatOk, jobStableOk, jobDoneOk, jobIdleOk);
      end
    end
  endtask

  task automatic test_max_len();
    longint expRes; bit expOvf;
    for (int i = 0; i < 255; i++) beatData[i] = IN_W'($urandom_range(255));
    refModel(ACC_W, IN_W, 255, 1'b0, expRes, expOvf);
    runJob(255, 1'b0, 0, -1, 0);
    checks++;
    if (jobData !== expRes[31:0] || jobTimeout || !jobLatOk) begin
      errors++; $display("[TB] FAIL max_len: got %h expected %h", jobData, expRes[31:0]);
    end
  endtask

  task automatic test_overflow8();
    longint expRes; bit expOvf;
    logic [7:0] expConst;
`ifdef NEUREKA_ACC_SATURATE_EN
    expConst = 8'h7F;
`else
    expConst = 8'hC8;
`endif
    beatData[0] = 28'd100;
    beatData[1] = 28'd100;
    refModel(8, 8, 2, 1'b1, expRes, expOvf);
    start8 = 1'b1; len8 = 8'd2; sgn8 = 1'b1;
    step();
    start8 = 1'b0;
    inValid8 = 1'b1; inData8 = 8'd100;
    step();
    step();
    inValid8 = 1'b0;
    checks++;
    if (accValid8 !== 1'b1 || accData8 !== expConst || accData8 !== expRes[7:0]) begin
      errors++; $display("[TB] FAIL ovf8_data: valid=%b data=%h expected 1 %h", accValid8, accData8,
                         expConst);
    end
    checks++;
    if (ovf8 !== 1'b1 || expOvf !== 1'b1) begin
      errors++; $display("[TB] FAIL ovf8_flag: got %b expected 1", ovf8);
    end
    accReady8 = 1'b1;
    step();
    accReady8 = 1'b0;
  endtask

  task automatic test_clear_midjob();
    bit sawValid;
    start = 1'b1; lenIn = 8'd4; sgnIn = 1'b0;
    step();
    start = 1'b0;
    inValid = 1'b1; inData = 28'd1;
    step();
    inData = 28'd2;
    step();
    inValid = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (inReady !== 1'b0 || busy !== 1'b0 || accValid !== 1'b0) begin
      errors++; $display("[TB] FAIL clear_state: ready=%b busy=%b valid=%b expected 0 0 0",
                         inReady, busy, accValid);
    end
    sawValid = 0;
    inValid = 1'b1; inData = 28'd9;
    for (int k = 0; k < 4; k++) begin
      step();
      if (accValid !== 1'b0 || busy !== 1'b0) sawValid = 1;
    end
    inValid = 1'b0;
    checks++;
    if (sawValid) begin
      errors++; $display("[TB] FAIL clear_no_output: aborted job produced activity, expected none");
    end
    beatData[0] = 28'd7;
    runJob(1, 1'b0, 0, -1, 0);
    checks++;
    if (jobData !== 32'd7 || jobOvf !== 1'b0 || jobTimeout) begin
      errors++; $display("[TB] FAIL clear_next_job: got %h expected 00000007", jobData);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed_backpressure();
    test_gaps_stall();
    test_len_zero();
    test_overflow32();
    test_back_to_back();
    test_random_jobs();
    test_max_len();
    test_overflow8();
    test_clear_midjob();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
